// File: rtl/sha256_block_scheduler.sv
// sha256_block_scheduler: SHA-256 message padding and block sequencer.
// Accepts 32-bit big-endian message words, applies the 0x80 / zero-fill /
// 64-bit length padding, and hands 512-bit blocks to the compression core
// one at a time with a start/done handshake.
// Optional feature: define SHA256_SCHED_ABORT_EN to add the `abort` input
// and the DRAIN state that waits out an in-flight compression.
module sha256_block_scheduler #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         core_start,
    output logic         core_init,
    output logic [511:0] core_block,
    input  logic         core_done,
    output logic         msg_done,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_LEN,
        S_ISSUE,
        S_WAIT
`ifdef SHA256_SCHED_ABORT_EN
        , S_DRAIN
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [31:0]       r_words [16];
    logic [4:0]        r_idx;        // next word slot to write, 0..16
    logic [LEN_W-1:0]  r_len;        // message bit length so far
    logic              r_first;      // current block is the first of its message
    logic              r_need80;     // full last word taken, 0x80 word not yet written
    logic              r_wrap;       // pad byte landed in word 14/15: length goes in a further block
    logic              r_final;      // current block carries the length field
    logic              r_msg_done;

    logic              w_accept;
    logic [2:0]        w_nbytes;
    logic              w_short;
    logic [31:0]       w_last_word;
    logic [LEN_W-1:0]  w_len_inc;
    logic [63:0]       w_len64;
    logic              w_abort;

`ifdef SHA256_SCHED_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = s_valid && (r_state == S_FILL);
    assign w_nbytes = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
    assign w_short  = s_last && (w_nbytes != 3'd4);
    assign w_len64  = 64'(r_len);

    // Word to store: a short last word keeps its top n bytes and takes the 0x80 marker in byte n
    always_comb begin
        w_last_word = s_data;
        if (w_short) begin
            unique case (w_nbytes)
                3'd0:    w_last_word = 32'h8000_0000;
                3'd1:    w_last_word = {s_data[31:24], 24'h80_0000};
                3'd2:    w_last_word = {s_data[31:16], 16'h8000};
                default: w_last_word = {s_data[31:8], 8'h80};
            endcase
        end
        w_len_inc = w_short ? LEN_W'({w_nbytes, 3'b000}) : LEN_W'(32);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        core_start  = 1'b0;
        core_init   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (s_valid) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                s_ready = 1'b1;
                if (w_accept) begin
                    if (s_last && (w_short || r_idx != 5'd15)) w_state_nxt = S_PAD;
                    else if (r_idx == 5'd15)                    w_state_nxt = S_ISSUE;
                end
            end
            S_PAD: begin
                if (!r_need80) begin
                    if (r_wrap && r_idx == 5'd16)       w_state_nxt = S_ISSUE;
                    else if (!r_wrap && r_idx == 5'd14) w_state_nxt = S_LEN;
                end
            end
            S_LEN: w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                core_start  = 1'b1;
                core_init   = r_first;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                core_init = r_first;
                if (core_done) begin
                    if (r_final)                  w_state_nxt = S_IDLE;
                    else if (r_wrap || r_need80)  w_state_nxt = S_PAD;
                    else                          w_state_nxt = S_FILL;
                end
            end
`ifdef SHA256_SCHED_ABORT_EN
            S_DRAIN: if (core_done) w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef SHA256_SCHED_ABORT_EN
        if (w_abort) begin
            unique case (r_state)
                S_FILL, S_PAD, S_LEN, S_ISSUE: w_state_nxt = S_IDLE;
                S_WAIT:  w_state_nxt = core_done ? S_IDLE : S_DRAIN;
                default: ;
            endcase
        end
`endif
    end

    assign msg_done = r_msg_done;

    // Block assembly: word 0 occupies the most significant 32 bits
    always_comb begin
        core_block = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            core_block[511 - 32*i -: 32] = r_words[i];
        end
    end

    // Datapath: word store, index, length counter and padding flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_len      <= '0;
            r_first    <= 1'b1;
            r_need80   <= 1'b0;
            r_wrap     <= 1'b0;
            r_final    <= 1'b0;
            r_msg_done <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            r_msg_done <= (r_state == S_WAIT) && core_done && r_final && !w_abort;
            unique case (r_state)
                S_IDLE: begin
                    r_idx    <= '0;
                    r_len    <= '0;
                    r_first  <= 1'b1;
                    r_need80 <= 1'b0;
                    r_wrap   <= 1'b0;
                    r_final  <= 1'b0;
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_words[r_idx[3:0]] <= w_last_word;
                        r_idx <= r_idx + 5'd1;
                        r_len <= r_len + w_len_inc;
                        if (s_last) begin
                            if (w_short) r_wrap   <= (r_idx >= 5'd14);
                            else         r_need80 <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    if (r_need80) begin
                        r_words[r_idx[3:0]] <= 32'h8000_0000;
                        r_need80 <= 1'b0;
                        r_wrap   <= (r_idx >= 5'd14);
                        r_idx    <= r_idx + 5'd1;
                    end else if (r_wrap ? (r_idx != 5'd16) : (r_idx != 5'd14)) begin
                        r_words[r_idx[3:0]] <= '0;
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_LEN: begin
                    r_words[14] <= w_len64[63:32];
                    r_words[15] <= w_len64[31:0];
                    r_final     <= 1'b1;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_first <= 1'b0;
                        r_idx   <= '0;
                        r_wrap  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
